// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter sharing one external ALU (define ALU_ARBITER_ROUND_ROBIN_EN for round-robin ties)
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] result,
  output logic        zero,
  output logic        err,
  output logic        busy,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        win;
  logic        pick;
  logic        legal;
  logic [3:0]  op_in;
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
  logic last;
  assign pick = (req0 && req1) ? ~last : ~req0;
  // remember who was granted last so the other side wins the next tie
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (state == IDLE && (req0 || req1)) last <= pick;
`else
  assign pick = ~req0;
`endif
  assign op_in  = pick ? op1 : op0;
  assign legal  = op_in inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
  assign busy   = state != IDLE;
  assign alu_op = (state == EXEC) ? op_q : 4'd0;
  assign alu_a  = (state == EXEC) ? a_q : 32'd0;
  assign alu_b  = (state == EXEC) ? b_q : 32'd0;
  // grant, execute on the shared ALU, then pulse the winner's ack for one cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state  <= IDLE;
      op_q   <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      win    <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      result <= 32'd0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE:
          if (req0 || req1) begin
            op_q <= op_in;
            a_q  <= pick ? a1 : a0;
            b_q  <= pick ? b1 : b0;
            win  <= pick;
            if (legal) state <= EXEC;
            else begin
              state  <= RESP;
              result <= 32'd0;
              zero   <= 1'b1;
              err    <= 1'b1;
              ack0   <= ~pick;
              ack1   <= pick;
            end
          end
        EXEC: begin
          state  <= RESP;
          result <= alu_result;
          zero   <= alu_zero;
          err    <= 1'b0;
          ack0   <= ~win;
          ack1   <= win;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench with a behavioural ALU model
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [3:0]  op0 = 4'd0, op1 = 4'd0;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
  logic        ack0, ack1, zero, err, busy, alu_zero;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  int          checks = 0;
  int          failures = 0;
  logic        rr;
  alu_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
    .result(result), .zero(zero), .err(err), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );
  always #5 clk = ~clk;
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'd0;
    endcase
  end
  assign alu_zero = alu_result == 32'd0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    reset = 1'b0;
    req0 = 1'b1; op0 = 4'b0010; a0 = 5; b0 = 7;
    tick();
    chk("add_exec_busy", busy, 1);
    chk("add_exec_ack0", ack0, 0);
    chk("add_exec_alu_op", alu_op, 4'b0010);
    chk("add_exec_alu_a", alu_a, 5);
    tick();
    chk("add_ack0", ack0, 1);
    chk("add_ack1", ack1, 0);
    chk("add_result", result, 12);
    chk("add_zero", zero, 0);
    chk("add_err", err, 0);
    chk("add_resp_alu_op", alu_op, 0);
    req0 = 1'b0;
    tick();
    chk("add_idle_ack0", ack0, 0);
    chk("add_idle_busy", busy, 0);
    chk("add_hold_result", result, 12);
    req1 = 1'b1; op1 = 4'b0110; a1 = 9; b1 = 9;
    tick();
    chk("sub_exec_ack1", ack1, 0);
    tick();
    chk("sub_ack1", ack1, 1);
    chk("sub_ack0", ack0, 0);
    chk("sub_result", result, 0);
    chk("sub_zero", zero, 1);
    chk("sub_err", err, 0);
    req1 = 1'b0;
    tick();
    chk("sub_idle_ack1", ack1, 0);
    req0 = 1'b1; op0 = 4'b0001; a0 = 1; b0 = 2;
    req1 = 1'b1; op1 = 4'b0001; a1 = 4; b1 = 8;
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
      chk("tie_ack0", ack0, (rr && i == 1) ? 0 : 1);
      chk("tie_ack1", ack1, (rr && i == 1) ? 1 : 0);
      chk("tie_result", result, (rr && i == 1) ? 12 : 3);
      if (i == 2) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
      chk("tie_idle_acks", {ack0, ack1}, 0);
    end
    req0 = 1'b1; op0 = 4'b1111; a0 = 6; b0 = 1;
    tick();
    chk("ill_ack0", ack0, 1);
    chk("ill_ack1", ack1, 0);
    chk("ill_result", result, 0);
    chk("ill_zero", zero, 1);
    chk("ill_err", err, 1);
    chk("ill_alu_op", alu_op, 0);
    chk("ill_busy", busy, 1);
    req0 = 1'b0;
    tick();
    chk("ill_idle_busy", busy, 0);
    req0 = 1'b1; op0 = 4'b0111; a0 = 3; b0 = 4;
    tick();
    chk("rst_mid_exec_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_ack0", ack0, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_zero", zero, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_alu_op", alu_op, 0);
    tick();
    chk("rst_hold_ack0", ack0, 0);
    reset = 1'b0;
    tick();
    chk("slt_exec_ack0", ack0, 0);
    tick();
    chk("slt_ack0", ack0, 1);
    chk("slt_result", result, 1);
    chk("slt_err", err, 0);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; op0 = 4'b0000; a0 = 5; b0 = 32'hF;
    tick();
    a0 = 100;
    tick();
    chk("and_ack0", ack0, 1);
    chk("and_result", result, 5);
    chk("and_zero", zero, 0);
    req0 = 1'b0;
    tick();
    chk("end_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
